// File: rtl/uart_pkg.sv
// Shared UART definitions: default link parameters used by the receiver and
// transmitter, plus the word-arbiter state encoding and header constants.
package uart_pkg;

    localparam int CLK_FRE    = 50;       // system clock in MHz
    localparam int BAUD_RATE  = 115200;
    localparam int DATA_WIDTH = 8;
    localparam int BYTE_W     = 8;

    // Upper nibble of the optional per-word header byte.
    localparam logic [3:0] HDR_NIBBLE = 4'hA;

    // One-hot word-arbiter states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_SEND = 3'b010,
        ST_WAIT = 3'b100
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first active request searching
// upward from last_grant+1 with wrap-around. Returns one-hot and encoded grant.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic found;
    int   idx;

    // Rotating priority search; the first hit in search order wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_word_arbiter.sv
// Shares one byte-wide UART transmitter among NUM_REQ 32-bit word producers.
// Grants round-robin, latches the word and sends its top WORD_BYTES bytes
// MSB-first, one byte per transmitter done pulse.
// Optional macro UART_TX_HDR_EN: prefix each word with {4'hA, 1'b0, id[2:0]}.
module uart_tx_word_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int WORD_BYTES = 4,
    parameter int ID_W       = 3
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [NUM_REQ*32-1:0] i_req_data,
    output logic [NUM_REQ-1:0]    o_req_ready,
    output logic [BYTE_W-1:0]     o_data_tx,
    output logic                  o_data_valid,
    input  logic                  i_out_done,
    output logic                  o_busy,
    output logic [ID_W-1:0]       o_grant_id
);

`ifdef UART_TX_HDR_EN
    localparam logic [2:0] LAST_CNT = 3'(WORD_BYTES + 1);
`else
    localparam logic [2:0] LAST_CNT = 3'(WORD_BYTES);
`endif

    tx_state_t          state, state_nxt;
    logic [31:0]        shift;
    logic [2:0]         cnt;
    logic [ID_W-1:0]    last_grant;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic [31:0]        word_sel;
    logic [BYTE_W-1:0]  tx_byte;
    logic               load, send, shift_en, finish;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req        (i_req_valid),
        .last_grant (last_grant),
        .grant      (gnt),
        .grant_id   (gnt_id)
    );

    // Mux out the granted requester's word for capture.
    always_comb begin
        word_sel = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (gnt[k]) word_sel = i_req_data[k*32 +: 32];
    end

    // State register.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; done pulses only matter in WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|i_req_valid) state_nxt = ST_SEND;
            ST_SEND: state_nxt = ST_WAIT;
            ST_WAIT: if (i_out_done) state_nxt = (cnt == LAST_CNT) ? ST_IDLE : ST_SEND;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Per-state datapath controls and the byte selected for transmission.
    always_comb begin
        load     = (state == ST_IDLE) && (|i_req_valid);
        send     = (state == ST_SEND);
        finish   = (state == ST_WAIT) && i_out_done && (cnt == LAST_CNT);
        tx_byte  = shift[31:24];
        shift_en = send;
`ifdef UART_TX_HDR_EN
        // Header goes out first; the data word stays put until the next SEND.
        if (cnt == 3'd0) begin
            tx_byte  = {HDR_NIBBLE, 1'b0, 3'(o_grant_id)};
            shift_en = 1'b0;
        end
`endif
    end

    // Registered outputs, word shifter, byte counter and round-robin pointer.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_req_ready  <= '0;
            o_data_tx    <= '0;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_grant_id   <= '0;
            shift        <= '0;
            cnt          <= '0;
            last_grant   <= ID_W'(NUM_REQ - 1);
        end else begin
            o_req_ready  <= load ? gnt : '0;
            o_data_valid <= send;
            if (load) begin
                shift      <= word_sel;
                o_grant_id <= gnt_id;
                last_grant <= gnt_id;
                o_busy     <= 1'b1;
            end
            if (send) begin
                o_data_tx <= tx_byte;
                cnt       <= cnt + 3'd1;
            end
            if (shift_en) shift <= {shift[23:0], 8'h00};
            if (finish) begin
                cnt    <= '0;
                o_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_word_arbiter.sv
// Scoreboard bench for uart_tx_word_arbiter: stimulus pushes expected grants
// and bytes; a monitor pops and compares on every ready pulse and byte strobe.
// A transmitter model answers each strobe with a done pulse 10 cycles later.
module tb_uart_tx_word_arbiter;

    localparam int NR = 2;
    localparam int WB = 4;
    localparam int IW = 3;
`ifdef UART_TX_HDR_EN
    localparam int NB = WB + 1;
`else
    localparam int NB = WB;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR*32-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [7:0]      data_tx;
    logic            data_valid;
    logic            out_done;
    logic            busy;
    logic [IW-1:0]   grant_id;
    logic            auto_done, spur;

    assign out_done = auto_done | spur;

    uart_tx_word_arbiter #(.NUM_REQ(NR), .WORD_BYTES(WB), .ID_W(IW)) dut (
        .i_clk_sys    (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .i_req_data   (req_data),
        .o_req_ready  (req_ready),
        .o_data_tx    (data_tx),
        .o_data_valid (data_valid),
        .i_out_done   (out_done),
        .o_busy       (busy),
        .o_grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_strobes = 0;
    int n_ready   = 0;
    logic [7:0] bq[$];
    int         gq[$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Queue expected grant and up to nmax bytes (header first when enabled).
    task automatic push_word(int id, logic [31:0] w, int nmax);
        int n = 0;
        gq.push_back(id);
`ifdef UART_TX_HDR_EN
        bq.push_back({4'hA, 1'b0, 3'(id)});
        n++;
`endif
        for (int i = 0; i < WB; i++)
            if (n < nmax) begin
                bq.push_back(w[31-8*i -: 8]);
                n++;
            end
    endtask

    // Monitor: compare every ready pulse and byte strobe against the queues.
    initial begin
        logic [7:0] eb;
        int         eg;
        forever begin
            @(negedge clk);
            if (rst_n && |req_ready) begin
                n_ready++;
                if (gq.size() == 0) chk("unexpected_ready", 32'(req_ready), 32'h0);
                else begin
                    eg = gq.pop_front();
                    chk("ready_onehot", 32'(req_ready), 32'(1) << eg);
                    chk("grant_id", 32'(grant_id), 32'(eg));
                end
            end
            if (rst_n && data_valid) begin
                n_strobes++;
                if (bq.size() == 0) chk("unexpected_byte", 32'(data_tx), 32'hFFFF_FFFF);
                else begin
                    eb = bq.pop_front();
                    chk("byte", 32'(data_tx), 32'(eb));
                end
            end
        end
    end

    // Transmitter model: done pulse 10 cycles after each strobe.
    initial begin
        auto_done = 1'b0;
        forever begin
            @(negedge clk);
            if (data_valid) begin
                repeat (10) @(posedge clk);
                #1 auto_done = 1'b1;
                @(posedge clk);
                #1 auto_done = 1'b0;
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(int k, string nm);
        logic seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (req_ready[k]) seen = 1'b1;
        end
        if (!seen) chk({nm, "_ready_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_idle(string nm);
        logic done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) chk({nm, "_idle_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int base, rbase;
        logic got;
        rst_n = 1'b0; req_valid = '0; req_data = '0; spur = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({req_ready, data_tx, data_valid, busy, grant_id}), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: single word from req0
        base = n_strobes;
        push_word(0, 32'h12345678, NB);
        req_data[31:0] = 32'h12345678; req_valid[0] = 1'b1;
        wait_ready(0, "t1");
        chk("t1_busy_high", 32'(busy), 32'h1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_idle("t1");
        chk("t1_strobes_at_busy_fall", 32'(n_strobes - base), 32'(NB));

        // 2: both held, grants alternate 0,1,0
        do_reset();
        base = n_strobes; rbase = n_ready;
        push_word(0, 32'hAAAA0001, NB);
        push_word(1, 32'hBBBB0002, NB);
        push_word(0, 32'hAAAA0001, NB);
        req_data = {32'hBBBB0002, 32'hAAAA0001}; req_valid = 2'b11;
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk);
            if (n_ready - rbase >= 3) got = 1'b1;
        end
        if (!got) chk("t2_ready_timeout", 32'h0, 32'h1);
        @(posedge clk); #1 req_valid = '0;
        wait_idle("t2");
        chk("t2_strobes", 32'(n_strobes - base), 32'(3 * NB));

        // 3: spurious done in IDLE and in SEND (last grant 0 -> req1 wins)
        base = n_strobes;
        step(2);
        spur = 1'b1; step(1); spur = 1'b0;
        push_word(1, 32'h11223344, NB);
        req_data[63:32] = 32'h11223344; req_valid[1] = 1'b1;
        wait_ready(1, "t3");
        spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0; req_valid[1] = 1'b0;
        wait_idle("t3");
        chk("t3_strobes", 32'(n_strobes - base), 32'(NB));

        // 4: reset after the second byte of 0xCAFEF00D
        base = n_strobes;
        push_word(0, 32'hCAFEF00D, 2);
        req_data[31:0] = 32'hCAFEF00D; req_valid[0] = 1'b1;
        wait_ready(0, "t4");
        @(posedge clk); #1 req_valid[0] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (n_strobes - base >= 2) got = 1'b1;
        end
        if (!got) chk("t4_strobe_timeout", 32'h0, 32'h1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk("t4_async_reset_outputs",
               32'({req_ready, data_tx, data_valid, busy, grant_id}), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(30);
        chk("t4_no_resend", 32'(n_strobes - base), 32'h2);
        chk("t4_busy_low", 32'(busy), 32'h0);

        // 5: req1 blips valid while req0 is busy -> never granted
        base = n_strobes; rbase = n_ready;
        push_word(0, 32'h55667788, NB);
        req_data = {32'h99999999, 32'h55667788}; req_valid[0] = 1'b1;
        wait_ready(0, "t5");
        @(posedge clk); #1 req_valid[0] = 1'b0;
        step(3);
        req_valid[1] = 1'b1; step(1); req_valid[1] = 1'b0;
        wait_idle("t5");
        step(5);
        chk("t5_ready_count", 32'(n_ready - rbase), 32'h1);
        chk("t5_strobes", 32'(n_strobes - base), 32'(NB));

        // 6: req1 sends 0x01020304 (header A1 first when enabled)
        push_word(1, 32'h01020304, NB);
        req_data[63:32] = 32'h01020304; req_valid[1] = 1'b1;
        wait_ready(1, "t6");
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_idle("t6");
        chk("t6_grant_id", 32'(grant_id), 32'h1);

        step(5);
        chk("bytes_left", 32'(bq.size()), 32'h0);
        chk("grants_left", 32'(gq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
